// File: rtl/plru_tracker_if.sv
// Op request / response bundle between the LLC tag controller and plru_tracker.
// req_valid_mask only exists when PLRU_VALID_PRIO_EN is defined.
interface plru_tracker_if #(
   parameter int NUM_WAYS = 8,
   parameter int NUM_SETS = 1024
);
   localparam int WAY_W = $clog2(NUM_WAYS);
   localparam int SET_W = $clog2(NUM_SETS);

   logic             flush;
   logic             req_valid;
   logic             req_ready;
   logic [1:0]       req_op;
   logic [SET_W-1:0] req_set;
   logic [WAY_W-1:0] req_way;
`ifdef PLRU_VALID_PRIO_EN
   logic [NUM_WAYS-1:0] req_valid_mask;
`endif
   logic             rsp_valid;
   logic [WAY_W-1:0] rsp_way;
   logic             init_busy;

   modport master (
`ifdef PLRU_VALID_PRIO_EN
      output req_valid_mask,
`endif
      output flush, req_valid, req_op, req_set, req_way,
      input  req_ready, rsp_valid, rsp_way, init_busy
   );

   modport slave (
`ifdef PLRU_VALID_PRIO_EN
      input  req_valid_mask,
`endif
      input  flush, req_valid, req_op, req_set, req_way,
      output req_ready, rsp_valid, rsp_way, init_busy
   );
endinterface

// File: rtl/plru_tracker.sv
// Per-set tree pseudo-LRU store and victim selector; rsp_way 1 cycle after accept, no rsp backpressure.
// req_ready low during the init sweep and on flush; PLRU_VALID_PRIO_EN adds invalid-way-first victims.
module plru_tracker #(
   parameter int NUM_WAYS = 8,
   parameter int NUM_SETS = 1024
) (
   input logic           clk,
   input logic           rst_n,
   plru_tracker_if.slave bus
);
   localparam int WAY_W     = $clog2(NUM_WAYS);
   localparam int SET_W     = $clog2(NUM_SETS);
   localparam int PLRU_SIZE = NUM_WAYS - 1;

   localparam logic [1:0] OP_TOUCH  = 2'b00;
   localparam logic [1:0] OP_VICTIM = 2'b01;
   localparam logic [1:0] OP_ALLOC  = 2'b10;
   localparam logic [1:0] OP_CLEAR  = 2'b11;

   localparam logic [SET_W-1:0] LAST_SET = SET_W'(NUM_SETS - 1);
   localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(NUM_WAYS - 1);

   typedef enum logic {ST_INIT, ST_RUN} state_e;

   state_e               state_q, state_d;
   logic [SET_W-1:0]     sweep_q, sweep_d;
   logic [PLRU_SIZE-1:0] plru_mem [NUM_SETS];
   logic [PLRU_SIZE-1:0] cur_bits;
   logic [WAY_W-1:0]     tree_way;
   logic [WAY_W-1:0]     victim;
   logic                 accept;
   logic [WAY_W-1:0]     rsp_way_d;
   logic                 mem_we;
   logic [SET_W-1:0]     mem_addr;
   logic [PLRU_SIZE-1:0] mem_wdata;
   logic                 rsp_valid_q;
   logic [WAY_W-1:0]     rsp_way_q;

   // Heap-ordered tree padded to NUM_WAYS bits so a WAY_W-bit node index covers it exactly.
   function automatic logic [WAY_W-1:0] tree_victim(input logic [PLRU_SIZE-1:0] tree);
      logic [NUM_WAYS-1:0] t;
      logic [WAY_W-1:0]    node;
      logic [WAY_W-1:0]    way;
      t    = {1'b0, tree};
      node = '0;
      way  = '0;
      for (int lvl = 0; lvl < WAY_W; lvl++) begin
         if (t[node]) begin
            way[WAY_W-1-lvl] = 1'b0;
            node = (node << 1) + WAY_W'(1);
         end else begin
            way[WAY_W-1-lvl] = 1'b1;
            node = (node << 1) + WAY_W'(2);
         end
      end
      return way;
   endfunction

   // Every node on the way's path points to the half that does not hold it.
   function automatic logic [PLRU_SIZE-1:0] tree_touch(input logic [PLRU_SIZE-1:0] tree,
                                                       input logic [WAY_W-1:0]     way);
      logic [NUM_WAYS-1:0] t;
      logic [WAY_W-1:0]    node;
      t    = {1'b0, tree};
      node = '0;
      for (int lvl = 0; lvl < WAY_W; lvl++) begin
         t[node] = way[WAY_W-1-lvl];
         node = (node << 1) + (way[WAY_W-1-lvl] ? WAY_W'(2) : WAY_W'(1));
      end
      return t[PLRU_SIZE-1:0];
   endfunction

`ifdef PLRU_VALID_PRIO_EN
   function automatic logic [WAY_W-1:0] first_invalid(input logic [NUM_WAYS-1:0] mask);
      logic [WAY_W-1:0] way;
      way = '0;
      for (int i = NUM_WAYS - 1; i >= 0; i--) begin
         if (!mask[i]) way = WAY_W'(i);
      end
      return way;
   endfunction
`endif

   // The array is written at the accepting edge, so the next op always reads the updated bits.
   assign cur_bits = plru_mem[bus.req_set];
   assign tree_way = tree_victim(cur_bits);

`ifdef PLRU_VALID_PRIO_EN
   assign victim = (&bus.req_valid_mask) ? tree_way : first_invalid(bus.req_valid_mask);
`else
   assign victim = tree_way;
`endif

   assign bus.req_ready = (state_q == ST_RUN) && !bus.flush;
   assign bus.init_busy = (state_q == ST_INIT);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_way   = rsp_way_q;

   always_comb begin
      state_d   = state_q;
      sweep_d   = sweep_q;
      accept    = 1'b0;
      rsp_way_d = bus.req_way;
      mem_we    = 1'b0;
      mem_addr  = sweep_q;
      mem_wdata = '0;
      case (state_q)
         ST_INIT: begin
            mem_we = 1'b1;
            if (bus.flush) begin
               sweep_d = '0;
            end else if (sweep_q == LAST_SET) begin
               state_d = ST_RUN;
               sweep_d = '0;
            end else begin
               sweep_d = sweep_q + 1'b1;
            end
         end
         ST_RUN: begin
            if (bus.flush) begin
               state_d = ST_INIT;
               sweep_d = '0;
            end else if (bus.req_valid) begin
               accept   = 1'b1;
               mem_addr = bus.req_set;
               case (bus.req_op)
                  OP_TOUCH: begin
                     mem_we    = 1'b1;
                     mem_wdata = tree_touch(cur_bits, bus.req_way);
                     rsp_way_d = bus.req_way;
                  end
                  OP_VICTIM: begin
                     rsp_way_d = victim;
                  end
                  OP_ALLOC: begin
                     mem_we    = 1'b1;
                     mem_wdata = tree_touch(cur_bits, victim);
                     rsp_way_d = victim;
                  end
                  OP_CLEAR: begin
                     mem_we    = 1'b1;
                     mem_wdata = '0;
                     rsp_way_d = LAST_WAY;
                  end
               endcase
            end
         end
         default: begin
            state_d = ST_INIT;
            sweep_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_INIT;
         sweep_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_way_q   <= '0;
      end else begin
         state_q     <= state_d;
         sweep_q     <= sweep_d;
         rsp_valid_q <= accept;
         if (accept) rsp_way_q <= rsp_way_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) plru_mem[mem_addr] <= mem_wdata;
   end
endmodule
